channel_rr_merge: RTL
=====================

# channel_rr_merge

Merges K upstream valid/ack channels onto one downstream channel through a single registered output stage. Arbitration is round-robin with an optional burst hold: a granted requester may keep the channel for up to `MaxBurst` consecutive transfers. Each output word is tagged with the index of its source. The block sits between several spike/event producers and a shared downstream resource, for example a shared FIFO, a serializer, or the host link.

## Interface
- `K`, default 4: number of input channels, at least 2.
- `N`, default 8: data width per channel.
- `MaxBurst`, default 1: maximum consecutive grants to one requester; 1 gives pure round-robin.
- `SrcW`, default `$clog2(K)`: width of the source tag.

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `reset`  in  1  asynchronous, active-low; state is cleared while `reset`==0.
- `in_d`  in  K*N  input data; channel i occupies bits [i*N +: N].
- `in_v`  in  K  per-input valid.
- `in_a`  out  K  per-input acknowledge; combinational, at most one bit high.
- `out_d`  out  N  registered output data.
- `out_src`  out  SrcW  registered index of the source of `out_d`.
- `out_v`  out  1  registered output valid.
- `out_a`  in  1  downstream acknowledge; may be combinational from the sink.

## Operation
- Transfer rule: a channel transfers on a posedge where v==1 and a==1. The sender holds v and d stable until that edge.
- Output stage: `load` = !out_v || out_a.
  - When `load` and a winner exists, `out_d`/`out_src` take the winner's data and index, and `out_v` goes to 1.
  - When `load` and there is no winner, `out_v` goes to 0.
  - When !`load`, the output stage holds.
- `in_a[w]` = `load` && `in_v[w]`, only for winner w. All other `in_a` bits are 0.
- Arbiter states:
  - OPEN: no holder. Winner is the first i with `in_v[i]`, searching from `last`+1 and wrapping modulo K.
  - HOLD: the holder h is the winner if `in_v[h]`==1; otherwise the arbiter behaves as in OPEN.
- Transitions, evaluated only on a posedge where an input transfer occurs:
  - Winner w equals holder and `cnt` < MaxBurst-1: stay in HOLD, `cnt`++.
  - New winner w, MaxBurst>1: go to HOLD with h=w and `cnt`=0.
  - `cnt` reaches MaxBurst-1, or MaxBurst==1: go to OPEN.
  - `last` is set to w on every transfer.
- No input transfer on a cycle where the holder dropped valid: go to OPEN. `last` is unchanged.
- `cnt` width is `$clog2(MaxBurst)`, minimum 1. It never exceeds MaxBurst-1.

## Timing
- Reset values: `out_v`=0, `out_d`=0, `out_src`=0, `in_a`=0, state=OPEN, `last`=K-1 (input 0 has first priority), `cnt`=0.
- Latency: input transfer at edge t gives `out_v`=1 from t through the edge at which the output is acknowledged.
- Throughput: one word per cycle when `out_a` is held at 1.
- Downstream stall (out_v=1, out_a=0): all `in_a`=0; output holds.
- Simultaneous output drain and input accept on the same edge is required; there is no bubble.
- An input valid with no other requesters is accepted on the first edge where `load`=1.
- Starvation bound: any asserted `in_v` is granted within (K-1)*MaxBurst output transfers.
- Reset mid-transfer: `out_v` drops asynchronously. The word held in the output register is discarded. Inputs keep their v and re-present after reset.
- `in_a` must have no path from `out_d`; it depends only on `in_v`, `out_v`, `out_a` and state.

## Structure
- Package `channel_arb_pkg` holds:
  - the `arb_state_t` enum {OPEN, HOLD};
  - a `src_width(K)` function returning max(1, $clog2(K)).
- Sub-module `rr_priority_pick` (K parameter): combinational.
  - Inputs: request vector and `last`.
  - Outputs: `found` and winner index.
  - Implemented by rotate, find-first and un-rotate.
- The top level is flattened ports only. Channel-interface adaptation is done by wrappers at the instantiation site.

## Test plan
- Reset release with all `in_v`=1 and `out_a`=1 (K=4, MaxBurst=1): `out_src` sequence 0,1,2,3,0; one word per cycle; each `in_a` pulses once per 4 cycles.
- MaxBurst=3, inputs 0 and 2 always valid: `out_src` sequence 0,0,0,2,2,2,0.
- MaxBurst=3, input 1 drops valid after 1 grant while input 3 is valid: next `out_src`=3; the arbiter returns to OPEN without waiting.
- `out_a` held 0 for 5 cycles with `out_v`=1: `out_d` stable; all `in_a`=0. When `out_a` returns to 1, the next word loads on the same edge.
- Random valids and random `out_a` sink, 10k cycles: scoreboard per-source order preserved, no loss or duplication, grant gap ≤ (K-1)*MaxBurst.
- Assert `reset`=0 mid-stream: `out_v`=0 immediately; after release, input 0 has first priority.

Source files
------------

// File: rtl/channel_arb_pkg.sv
// Shared types and helpers for the round-robin channel merge.
// Arbiter state encoding and source-tag width helper.
package channel_arb_pkg;

  typedef enum logic {
    OPEN,
    HOLD
  } arb_state_t;

  function automatic int src_width(input int k);
    return ($clog2(k) < 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first request after `last`, wrapping mod K.
// Rotate so `last`+1 sits at bit 0, find-first, then un-rotate.
module rr_priority_pick
  import channel_arb_pkg::*;
#(
  parameter int K = 4,
  parameter int W = src_width(K)
) (
  input  logic [K-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [K-1:0] rot;
  int first;
  int pos;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    first = 0;
    pos   = 0;
    idx   = '0;
    for (int j = 0; j < K; j++)
      rot[j] = req[(int'(last) + 1 + j) % K];
    for (int j = K - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        first = j;
      end
    end
    pos = (int'(last) + 1 + first) % K;
    idx = W'(pos);
  end

endmodule

// File: rtl/channel_rr_merge.sv
// K-input valid/ack merge with round-robin + burst-hold arbitration
// and a single registered output stage tagged with the source index.
module channel_rr_merge
  import channel_arb_pkg::*;
#(
  parameter int K        = 4,
  parameter int N        = 8,
  parameter int MaxBurst = 1,
  parameter int SrcW     = src_width(K)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [K*N-1:0]  in_d,
  input  logic [K-1:0]    in_v,
  output logic [K-1:0]    in_a,
  output logic [N-1:0]    out_d,
  output logic [SrcW-1:0] out_src,
  output logic            out_v,
  input  logic            out_a
);

  localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

  arb_state_t      state;
  logic [SrcW-1:0] last;
  logic [SrcW-1:0] hold;
  logic [SrcW-1:0] pick;
  logic [SrcW-1:0] win;
  logic [CntW-1:0] cnt;
  logic            pick_ok;
  logic            keep;
  logic            found;
  logic            load;
  logic            xfer;

  rr_priority_pick #(
    .K(K),
    .W(SrcW)
  ) u_pick (
    .req  (in_v),
    .last (last),
    .found(pick_ok),
    .idx  (pick)
  );

  // Holder keeps priority only while it still requests.
  assign keep  = (state == HOLD) && in_v[hold];
  assign found = keep || pick_ok;
  assign win   = keep ? hold : pick;
  assign load  = !out_v || out_a;
  assign xfer  = load && found && reset;

  always_comb begin
    in_a = '0;
    if (xfer) in_a[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v   <= 1'b0;
      out_d   <= '0;
      out_src <= '0;
      state   <= OPEN;
      last    <= SrcW'(K - 1);
      hold    <= '0;
      cnt     <= '0;
    end else begin
      if (load) begin
        out_v <= found;
        if (found) begin
          out_d   <= in_d[int'(win)*N +: N];
          out_src <= win;
        end
      end
      if (xfer) begin
        last <= win;
        if (MaxBurst == 1) begin
          state <= OPEN;
          cnt   <= '0;
        end else if (keep) begin
          if (int'(cnt) + 1 >= MaxBurst - 1) begin
            state <= OPEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          state <= HOLD;
          hold  <= win;
          cnt   <= '0;
        end
      end else if (state == HOLD && !in_v[hold]) begin
        state <= OPEN;
        cnt   <= '0;
      end
    end
  end

endmodule
